// File: rtl/systolic_array_wl_stage_if.sv
// ---------------------------------------------------------------------------
// systolic_array_wl_stage_if
//   Bundles every non-clock signal of the weight-load stage:
//     - instruction issue : start_i, instr_*_i, wl_ready_o
//     - array status      : weight_busy_i
//     - RF read channel   : rf_rd_req_o/reg_o/row_o, rf_rd_gnt_i,
//                           rf_rd_rvalid_i, rf_rd_rdata_i
//     - weight write      : weight_we_o (one-hot row), weight_data_o
//     - feed handoff      : ff_valid_o, ff_ready_i, ff_ms1_o/md_o/op_o
//     - status            : busy_o
//   Suffixes are from the stage's point of view.
//   master : the weight-load stage.
//   slave  : its environment (issue queue, register file, array, feed stage).
// ---------------------------------------------------------------------------
interface systolic_array_wl_stage_if #(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_IDX_W  = 3,
    parameter int OP_W       = 2
);
    logic                           start_i;
    logic [REG_IDX_W-1:0]           instr_ms1_i;
    logic [REG_IDX_W-1:0]           instr_ms2_i;
    logic [REG_IDX_W-1:0]           instr_md_i;
    logic [OP_W-1:0]                instr_op_i;
    logic                           wl_ready_o;
    logic                           weight_busy_i;
    logic                           rf_rd_req_o;
    logic [REG_IDX_W-1:0]           rf_rd_reg_o;
    logic [$clog2(N_ROWS)-1:0]      rf_rd_row_o;
    logic                           rf_rd_gnt_i;
    logic                           rf_rd_rvalid_i;
    logic [N_COLS*DATA_WIDTH-1:0]   rf_rd_rdata_i;
    logic [N_ROWS-1:0]              weight_we_o;
    logic [N_COLS*DATA_WIDTH-1:0]   weight_data_o;
    logic                           ff_valid_o;
    logic                           ff_ready_i;
    logic [REG_IDX_W-1:0]           ff_ms1_o;
    logic [REG_IDX_W-1:0]           ff_md_o;
    logic [OP_W-1:0]                ff_op_o;
    logic                           busy_o;

    modport master (
        input  start_i, instr_ms1_i, instr_ms2_i, instr_md_i, instr_op_i,
        output wl_ready_o,
        input  weight_busy_i,
        output rf_rd_req_o, rf_rd_reg_o, rf_rd_row_o,
        input  rf_rd_gnt_i, rf_rd_rvalid_i, rf_rd_rdata_i,
        output weight_we_o, weight_data_o,
        output ff_valid_o,
        input  ff_ready_i,
        output ff_ms1_o, ff_md_o, ff_op_o,
        output busy_o
    );

    modport slave (
        output start_i, instr_ms1_i, instr_ms2_i, instr_md_i, instr_op_i,
        input  wl_ready_o,
        output weight_busy_i,
        input  rf_rd_req_o, rf_rd_reg_o, rf_rd_row_o,
        output rf_rd_gnt_i, rf_rd_rvalid_i, rf_rd_rdata_i,
        input  weight_we_o, weight_data_o,
        input  ff_valid_o,
        output ff_ready_i,
        input  ff_ms1_o, ff_md_o, ff_op_o,
        input  busy_o
    );
endinterface

// File: rtl/systolic_array_wl_stage.sv
// ---------------------------------------------------------------------------
// systolic_array_wl_stage
//   Weight-load stage of the systolic array. It takes one issued instruction
//   per start pulse and waits for the array weights to be free. It then reads
//   the N_ROWS rows of register ms2 from the matrix register file, writes each
//   returned row into the array weight registers, and hands the instruction
//   to the feed/accumulate stage over a valid/ready handshake.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   bus     : systolic_array_wl_stage_if.master (issue, RF read channel,
//             weight write, feed handoff, busy status)
// ---------------------------------------------------------------------------
module systolic_array_wl_stage #(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_IDX_W  = 3,
    parameter int OP_W       = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    systolic_array_wl_stage_if.master  bus
);

    localparam int RW = $clog2(N_ROWS);
    localparam int CW = RW + 1;
    localparam logic [CW-1:0] ROWS_C = CW'(N_ROWS);
    localparam logic [CW-1:0] LAST_C = CW'(N_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_W  = 2'd1,
        REQ     = 2'd2,
        HANDOFF = 2'd3
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        req_cnt_q;
    logic [CW-1:0]        rsp_cnt_q;
    logic [REG_IDX_W-1:0] ms1_q;
    logic [REG_IDX_W-1:0] ms2_q;
    logic [REG_IDX_W-1:0] md_q;
    logic [OP_W-1:0]      op_q;
    logic                 wl_ready_q;
    logic                 ff_valid_q;
    logic                 busy_q;

    logic rf_req;
    logic req_fire;
    logic rsp_fire;

    // Requests run ahead of responses; the two counters advance independently.
    assign rf_req   = (state_q == REQ) && (req_cnt_q < ROWS_C);
    assign req_fire = rf_req && bus.rf_rd_gnt_i;
    // rvalid is only honoured in REQ and only for the first N_ROWS responses,
    // so stale responses after an aborting reset never reach the array.
    assign rsp_fire = (state_q == REQ) && bus.rf_rd_rvalid_i && (rsp_cnt_q < ROWS_C);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            ms1_q      <= '0;
            ms2_q      <= '0;
            md_q       <= '0;
            op_q       <= '0;
            wl_ready_q <= 1'b1;
            ff_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        ms1_q      <= bus.instr_ms1_i;
                        ms2_q      <= bus.instr_ms2_i;
                        md_q       <= bus.instr_md_i;
                        op_q       <= bus.instr_op_i;
                        req_cnt_q  <= '0;
                        rsp_cnt_q  <= '0;
                        state_q    <= WAIT_W;
                        wl_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                WAIT_W: begin
                    if (!bus.weight_busy_i) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (req_fire) begin
                        req_cnt_q <= req_cnt_q + CW'(1);
                    end
                    if (rsp_fire) begin
                        rsp_cnt_q <= rsp_cnt_q + CW'(1);
                        if (rsp_cnt_q == LAST_C) begin
                            state_q    <= HANDOFF;
                            ff_valid_q <= 1'b1;
                        end
                    end
                end
                HANDOFF: begin
                    if (bus.ff_ready_i) begin
                        state_q    <= IDLE;
                        ff_valid_q <= 1'b0;
                        wl_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Weight row write is combinational from the response so the row lands
    // in the array in the same cycle rvalid is seen.
    always_comb begin
        bus.weight_we_o   = '0;
        bus.weight_data_o = '0;
        if (rsp_fire) begin
            bus.weight_we_o[rsp_cnt_q[RW-1:0]] = 1'b1;
            bus.weight_data_o                  = bus.rf_rd_rdata_i;
        end
    end

    assign bus.wl_ready_o  = wl_ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.rf_rd_req_o = rf_req;
    assign bus.rf_rd_reg_o = ms2_q;
    assign bus.rf_rd_row_o = req_cnt_q[RW-1:0];
    assign bus.ff_valid_o  = ff_valid_q;
    assign bus.ff_ms1_o    = ms1_q;
    assign bus.ff_md_o     = md_q;
    assign bus.ff_op_o     = op_q;

endmodule

// File: tb/tb_systolic_array_wl_stage.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_wl_stage
//   Directed bench for systolic_array_wl_stage. Inputs change on the falling
//   edge, and outputs are sampled shortly after it. Cycle numbers are counted
//   from the cycle in which start_i is presented (cycle 0).
// ---------------------------------------------------------------------------
module tb_systolic_array_wl_stage;

    localparam int N_ROWS     = 4;
    localparam int N_COLS     = 4;
    localparam int DATA_WIDTH = 32;
    localparam int REG_IDX_W  = 3;
    localparam int OP_W       = 2;
    localparam int BW         = N_COLS * DATA_WIDTH;
    localparam logic [BW-1:0] JUNK = {N_COLS{32'hDEAD_BEEF}};

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    systolic_array_wl_stage_if #(
        .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DATA_WIDTH(DATA_WIDTH),
        .REG_IDX_W(REG_IDX_W), .OP_W(OP_W)
    ) bus ();

    systolic_array_wl_stage #(
        .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DATA_WIDTH(DATA_WIDTH),
        .REG_IDX_W(REG_IDX_W), .OP_W(OP_W)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Flags start_i presented while the stage is not ready.
    int ignored_starts = 0;
    always @(posedge clk_i) begin
        if (rst_ni && bus.start_i && !bus.wl_ready_o) ignored_starts++;
    end

    function automatic logic [BW-1:0] rowdata(input int r);
        logic [BW-1:0] d;
        d = '0;
        for (int k = 0; k < N_COLS; k++)
            d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(32'hC0DE_0000 + r * 256 + k);
        return d;
    endfunction

    // Event logs for one instruction
    int                req_cyc[$];
    int                req_row[$];
    int                req_reg[$];
    int                stall_row[$];
    int                wr_cyc[$];
    logic [N_ROWS-1:0] wr_we[$];
    logic [BW-1:0]     wr_dat[$];
    int                ffv_cyc, rdy_cyc, hold_bad, zero_bad;
    logic [REG_IDX_W-1:0] ffv_ms1, ffv_md;
    logic [OP_W-1:0]      ffv_op;

    task automatic clear_inputs();
        bus.start_i        = 1'b0;
        bus.instr_ms1_i    = '0;
        bus.instr_ms2_i    = '0;
        bus.instr_md_i     = '0;
        bus.instr_op_i     = '0;
        bus.weight_busy_i  = 1'b0;
        bus.rf_rd_gnt_i    = 1'b0;
        bus.rf_rd_rvalid_i = 1'b0;
        bus.rf_rd_rdata_i  = '0;
        bus.ff_ready_i     = 1'b0;
    endtask

    // Runs one instruction with a small register-file/array/feed model.
    task automatic run_instr(input string t,
                             input logic [REG_IDX_W-1:0] ms1, ms2, md,
                             input logic [OP_W-1:0] op,
                             input int busy_n, input bit gnt_alt, input int rv_gap,
                             input int ffr_wait, input bit hold_starts);
        int due_q[$];
        int last_due, rsp_i, hold_cnt, d;
        bit done;
        req_cyc.delete(); req_row.delete(); req_reg.delete(); stall_row.delete();
        wr_cyc.delete(); wr_we.delete(); wr_dat.delete();
        ffv_cyc = -1; rdy_cyc = -1; hold_bad = 0; zero_bad = 0;
        last_due = -100; rsp_i = 0; hold_cnt = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                check_eq({t, "_ready_at_start"}, bus.wl_ready_o, 1);
            end else if (bus.wl_ready_o) begin
                rdy_cyc = c;
                done    = 1'b1;
            end
            if (!done) begin
                bus.start_i = (c == 0) ||
                              (hold_starts && bus.ff_valid_o && hold_cnt < ffr_wait);
                bus.instr_ms1_i = (c == 0) ? ms1 : ~ms1;
                bus.instr_ms2_i = (c == 0) ? ms2 : ~ms2;
                bus.instr_md_i  = (c == 0) ? md  : ~md;
                bus.instr_op_i  = (c == 0) ? op  : ~op;
                bus.weight_busy_i = (c >= 1 && c <= busy_n);
                if (due_q.size() > 0 && due_q[0] <= c) begin
                    bus.rf_rd_rvalid_i = 1'b1;
                    bus.rf_rd_rdata_i  = rowdata(rsp_i);
                    rsp_i++;
                    void'(due_q.pop_front());
                end else begin
                    bus.rf_rd_rvalid_i = 1'b0;
                    bus.rf_rd_rdata_i  = JUNK;
                end
                bus.rf_rd_gnt_i = bus.rf_rd_req_o && (gnt_alt ? (c % 2 == 1) : 1'b1);
                bus.ff_ready_i  = bus.ff_valid_o && (hold_cnt >= ffr_wait);
                #1;
                if (bus.rf_rd_req_o && bus.rf_rd_gnt_i) begin
                    req_cyc.push_back(c);
                    req_row.push_back(int'(bus.rf_rd_row_o));
                    req_reg.push_back(int'(bus.rf_rd_reg_o));
                    d = c + 1;
                    if (last_due + rv_gap > d) d = last_due + rv_gap;
                    due_q.push_back(d);
                    last_due = d;
                end else if (bus.rf_rd_req_o) begin
                    stall_row.push_back(int'(bus.rf_rd_row_o));
                end
                if (bus.weight_we_o != '0) begin
                    wr_cyc.push_back(c);
                    wr_we.push_back(bus.weight_we_o);
                    wr_dat.push_back(bus.weight_data_o);
                end else if (bus.weight_data_o != '0) begin
                    zero_bad++;
                end
                if (bus.ff_valid_o) begin
                    if (ffv_cyc < 0) begin
                        ffv_cyc = c;
                        ffv_ms1 = bus.ff_ms1_o;
                        ffv_md  = bus.ff_md_o;
                        ffv_op  = bus.ff_op_o;
                    end else if (bus.ff_ms1_o !== ffv_ms1 || bus.ff_md_o !== ffv_md ||
                                 bus.ff_op_o !== ffv_op) begin
                        hold_bad++;
                    end
                    if (bus.wl_ready_o !== 1'b0) hold_bad++;
                    hold_cnt++;
                end
            end
        end
        check_eq({t, "_completed"}, done, 1);
        clear_inputs();
    endtask

    // Compares the logs against hand-computed cycle numbers.
    task automatic check_run(input string t, input int r0, rs, w0, ws, effv, erdy,
                             input int ems1, ems2, emd, eop);
        check_eq({t, "_n_req"}, req_cyc.size(), N_ROWS);
        for (int i = 0; i < req_cyc.size() && i < N_ROWS; i++) begin
            check_eq($sformatf("%s_req%0d_cyc", t, i), req_cyc[i], r0 + i * rs);
            check_eq($sformatf("%s_req%0d_row", t, i), req_row[i], i);
            check_eq($sformatf("%s_req%0d_reg", t, i), req_reg[i], ems2);
        end
        check_eq({t, "_n_wr"}, wr_cyc.size(), N_ROWS);
        for (int i = 0; i < wr_cyc.size() && i < N_ROWS; i++) begin
            check_eq($sformatf("%s_wr%0d_cyc", t, i), wr_cyc[i], w0 + i * ws);
            check_eq($sformatf("%s_wr%0d_we", t, i), wr_we[i], 1 << i);
            check_eq($sformatf("%s_wr%0d_data", t, i), wr_dat[i], rowdata(i));
        end
        check_eq({t, "_ffv_cyc"}, ffv_cyc, effv);
        check_eq({t, "_ff_ms1"}, ffv_ms1, ems1);
        check_eq({t, "_ff_md"}, ffv_md, emd);
        check_eq({t, "_ff_op"}, ffv_op, eop);
        check_eq({t, "_rdy_cyc"}, rdy_cyc, erdy);
        check_eq({t, "_hold_stable"}, hold_bad, 0);
        check_eq({t, "_data_zero_when_idle"}, zero_bad, 0);
    endtask

    initial begin
        int idle_bad;
        int starts_before;
        clear_inputs();
        rst_ni = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_wl_ready", bus.wl_ready_o, 1);
        check_eq("rst_busy", bus.busy_o, 0);
        check_eq("rst_req", bus.rf_rd_req_o, 0);
        check_eq("rst_reg", bus.rf_rd_reg_o, 0);
        check_eq("rst_row", bus.rf_rd_row_o, 0);
        check_eq("rst_we", bus.weight_we_o, 0);
        check_eq("rst_data", bus.weight_data_o, 0);
        check_eq("rst_ff_valid", bus.ff_valid_o, 0);
        check_eq("rst_ff_ms1", bus.ff_ms1_o, 0);
        check_eq("rst_ff_md", bus.ff_md_o, 0);
        check_eq("rst_ff_op", bus.ff_op_o, 0);
        rst_ni = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            bus.rf_rd_rvalid_i = (i == 2);   // stray response while idle
            bus.rf_rd_rdata_i  = JUNK;
            bus.ff_ready_i     = (i == 1);   // stray accept while idle
            #1;
            if (bus.rf_rd_req_o || bus.weight_we_o != '0 || bus.weight_data_o != '0 ||
                bus.busy_o || !bus.wl_ready_o || bus.ff_valid_o) idle_bad++;
        end
        check_eq("idle_quiet", idle_bad, 0);
        clear_inputs();

        // Single instruction, minimum latency
        run_instr("single", 3'd1, 3'd5, 3'd2, 2'd1, 0, 1'b0, 1, 0, 1'b0);
        check_run("single", 2, 1, 3, 1, 7, 8, 1, 5, 2, 1);

        // Weights busy for 10 cycles after start
        run_instr("wbusy", 3'd3, 3'd7, 3'd4, 2'd2, 10, 1'b0, 1, 0, 1'b0);
        check_run("wbusy", 12, 1, 13, 1, 17, 18, 3, 7, 4, 2);

        // Grant on odd cycles only, responses spaced 4 cycles apart
        run_instr("stall", 3'd6, 3'd2, 3'd5, 2'd3, 0, 1'b1, 4, 0, 1'b0);
        check_run("stall", 3, 2, 4, 4, 17, 18, 6, 2, 5, 3);
        check_eq("stall_n_held", stall_row.size(), 4);
        for (int i = 0; i < stall_row.size() && i < 4; i++)
            check_eq($sformatf("stall_held%0d_row", i), stall_row[i], i);

        // Feed stage back-pressure for 5 cycles with start pulses during hold
        starts_before = ignored_starts;
        run_instr("ffhold", 3'd7, 3'd1, 3'd6, 2'd0, 0, 1'b0, 1, 5, 1'b1);
        check_run("ffhold", 2, 1, 3, 1, 7, 13, 7, 1, 6, 0);
        check_eq("ffhold_starts_flagged", ignored_starts - starts_before, 5);

        // Reset after two rows written, then a late response
        @(negedge clk_i);                                   // cycle 0
        bus.start_i = 1'b1; bus.instr_ms1_i = 3'd2; bus.instr_ms2_i = 3'd3;
        bus.instr_md_i = 3'd4; bus.instr_op_i = 2'd2;
        @(negedge clk_i);                                   // cycle 1: WAIT_W
        bus.start_i = 1'b0;
        @(negedge clk_i);                                   // cycle 2: row 0 granted
        bus.rf_rd_gnt_i = 1'b1;
        @(negedge clk_i);                                   // cycle 3: write row 0
        bus.rf_rd_rvalid_i = 1'b1; bus.rf_rd_rdata_i = rowdata(0);
        #1 check_eq("abort_wr0_we", bus.weight_we_o, 4'b0001);
        @(negedge clk_i);                                   // cycle 4: write row 1
        bus.rf_rd_rdata_i = rowdata(1);
        #1 check_eq("abort_wr1_we", bus.weight_we_o, 4'b0010);
        check_eq("abort_row_c4", bus.rf_rd_row_o, 2);
        @(negedge clk_i);                                   // cycle 5: reset edge
        rst_ni = 1'b0; bus.rf_rd_gnt_i = 1'b0; bus.rf_rd_rvalid_i = 1'b0;
        @(negedge clk_i);                                   // cycle 6: late response
        rst_ni = 1'b1; bus.rf_rd_rvalid_i = 1'b1; bus.rf_rd_rdata_i = rowdata(2);
        #1;
        check_eq("abort_late_we", bus.weight_we_o, 0);
        check_eq("abort_late_data", bus.weight_data_o, 0);
        check_eq("abort_wl_ready", bus.wl_ready_o, 1);
        check_eq("abort_busy", bus.busy_o, 0);
        check_eq("abort_req", bus.rf_rd_req_o, 0);
        check_eq("abort_ff_valid", bus.ff_valid_o, 0);
        @(negedge clk_i);
        clear_inputs();
        #1 check_eq("abort_still_idle", bus.wl_ready_o, 1);
        run_instr("after_abort", 3'd5, 3'd6, 3'd1, 2'd3, 0, 1'b0, 1, 0, 1'b0);
        check_run("after_abort", 2, 1, 3, 1, 7, 8, 5, 6, 1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
